// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - initiator side of the multiply/divide unit Start/Busy handshake
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   E_md_start, E_md_op   E-stage MD request and its opcode
//   E_rs, E_rt            forwarded operands, latched into DataA/DataB on accept
//   D_md_use              D-stage instruction touches the MD unit or HI/LO
//   E_rd_hi, E_rd_lo      E-stage mfhi / mflo select for md_rdata
//   Busy, HI, LO          from the MD unit
//   Start                 one-cycle request pulse to the MD unit
//   DataA, DataB, MDctrl  operands and opcode, held from Start until the next accept
//   stall_md              freeze PC/IF-ID and bubble E while the unit is in use
//   md_rdata              HI/LO readback mux (combinational)
//   proto_err             sticky Busy handshake violation
//   timeout_err           sticky watchdog abort

module md_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_md_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_md_use,
    input  logic        E_rd_hi,
    input  logic        E_rd_lo,
    input  logic        Busy,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic        Start,
    output logic [31:0] DataA,
    output logic [31:0] DataB,
    output logic [2:0]  MDctrl,
    output logic        stall_md,
    output logic [31:0] md_rdata,
    output logic        proto_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MTX    = 2'd1,
        S_ISSUED = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // cnt holds the number of ISSUED/WAIT cycles already completed, so the
    // cycle in which it equals TIMEOUT-1 is the last one allowed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    // The first WAIT cycle always follows exactly one ISSUED cycle.
    localparam logic [CNT_W-1:0] CNT_FIRST_WAIT = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            Start       <= 1'b0;
            DataA       <= '0;
            DataB       <= '0;
            MDctrl      <= '0;
            cnt         <= '0;
            proto_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Start is only raised on the accepting edge, so it can never
            // stay high for more than the single MTX/ISSUED cycle.
            Start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (E_md_start) begin
                        DataA  <= E_rs;
                        DataB  <= E_rt;
                        MDctrl <= E_md_op;
                        Start  <= 1'b1;
                        if (E_md_op[2]) begin
                            // mthi/mtlo: the unit writes HI/LO without a Busy phase
                            state <= S_MTX;
                        end else begin
                            state <= S_ISSUED;
                            cnt   <= '0;
                        end
                    end
                end

                S_MTX: begin
                    if (Busy) begin
                        proto_err <= 1'b1;
                    end
                    state <= S_IDLE;
                end

                S_ISSUED: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (!Busy) begin
                        // Busy low on the very first WAIT cycle means the unit
                        // never acknowledged the Start pulse.
                        if (cnt == CNT_FIRST_WAIT) begin
                            proto_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase

            // A request arriving while an operation is in flight means the
            // upstream stall failed; the request is dropped.
            if (E_md_start && (state != S_IDLE)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Combinational so an MD-dependent instruction directly behind an MD op
    // in E is held in D on the same cycle the op is presented.
    assign stall_md = D_md_use & ((state != S_IDLE) | E_md_start);

    always_comb begin
        md_rdata = '0;
        if (E_rd_hi) begin
            md_rdata = HI;
        end else if (E_rd_lo) begin
            md_rdata = LO;
        end
    end

endmodule
